// File: rtl/replay_fifo.sv
// rtl/replay_fifo.sv - link-layer replay buffer: FIFO with ACK-based retention and NAK-driven replay
module replay_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  EN,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  WR,
  input  logic                  RD,
  input  logic                  ACK,
  input  logic [ADDR_WIDTH:0]   ACK_NUM,
  input  logic                  NAK,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic [ADDR_WIDTH:0]   OCC,
  output logic [ADDR_WIDTH:0]   INFLIGHT,
  output logic                  REPLAYING,
  output logic                  OVF,
  output logic                  UNF,
  output logic                  ACK_ERR
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, ack_ptr, replay_mark;
  logic                  replaying;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ovf_q, unf_q, ack_err_q;

  logic [ADDR_WIDTH:0]   occ, inflight, rdcnt;
  logic                  full, empty;
  logic                  wr_acc, rd_acc, ack_acc, nak_fire;
  logic [ADDR_WIDTH:0]   ack_new, rd_inc, mark_dist, rd_lag, nak_inflight;
  logic                  ack_clear;
  logic [ADDR_WIDTH:0]   wr_nxt, rd_nxt, mark_nxt;
  logic                  rep_nxt;

  // Derived counts and request qualification, all from pre-edge state.
  always_comb begin
    occ       = wr_ptr - ack_ptr;
    inflight  = rd_ptr - ack_ptr;
    rdcnt     = wr_ptr - rd_ptr;
    full      = (occ == DEPTH);
    empty     = (rdcnt == '0);
    wr_acc    = EN & WR & ~full;
    rd_acc    = EN & RD & ~empty & ~NAK;
    ack_acc   = EN & ACK & (ACK_NUM <= inflight);
    nak_fire  = EN & NAK;
    ack_new   = ack_acc ? (ack_ptr + ACK_NUM) : ack_ptr;
    rd_inc    = rd_ptr + 1'b1;
    mark_dist = replay_mark - ack_ptr;
    // A NAK sees the ACK of the same cycle; the suppressed read leaves rd_ptr as-is.
    nak_inflight = rd_ptr - ack_new;
  end

  // Next-state for pointers and replay tracking; NAK is applied last so it wins over the read.
  always_comb begin
    wr_nxt    = wr_acc ? (wr_ptr + 1'b1) : wr_ptr;
    rd_nxt    = rd_acc ? rd_inc : rd_ptr;
    rep_nxt   = replaying;
    mark_nxt  = replay_mark;
    ack_clear = 1'b0;
    rd_lag    = '0;
    if (replaying && rd_acc && (rd_inc == replay_mark)) begin
      rep_nxt = 1'b0;
    end
    if (replaying && ack_acc && (ACK_NUM != '0) && (mark_dist <= ACK_NUM)) begin
      ack_clear = 1'b1;
      rep_nxt   = 1'b0;
      rd_lag    = rd_nxt - ack_ptr;
      if (rd_lag < ACK_NUM) begin
        rd_nxt = ack_new;
      end
    end
    if (nak_fire) begin
      rd_nxt = ack_new;
      if (nak_inflight != '0) begin
        rep_nxt = 1'b1;
        // A NAK during an ongoing replay restarts it but keeps the original high-water mark.
        if (!(replaying && !ack_clear)) begin
          mark_nxt = rd_ptr;
        end
      end
    end
  end

  // Storage array; no reset, stale entries are unreachable once pointers clear.
  always_ff @(posedge Clk) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= dataIn;
    end
  end

  // Pointer, read-data and error-pulse registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ack_ptr     <= '0;
      replay_mark <= '0;
      replaying   <= 1'b0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      ack_err_q   <= 1'b0;
    end else begin
      wr_ptr      <= wr_nxt;
      rd_ptr      <= rd_nxt;
      ack_ptr     <= ack_new;
      replay_mark <= mark_nxt;
      replaying   <= rep_nxt;
      if (rd_acc) begin
        data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
      ovf_q     <= EN & WR & full;
      unf_q     <= EN & RD & empty & ~NAK;
      ack_err_q <= EN & ACK & (ACK_NUM > inflight);
    end
  end

  assign dataOut   = data_q;
  assign EMPTY     = empty;
  assign FULL      = full;
  assign OCC       = occ;
  assign INFLIGHT  = inflight;
  assign REPLAYING = replaying;
  assign OVF       = ovf_q;
  assign UNF       = unf_q;
  assign ACK_ERR   = ack_err_q;

endmodule

// File: tb/tb_replay_fifo.sv
// tb/tb_replay_fifo.sv - scoreboard testbench for replay_fifo
module tb_replay_fifo;

  logic        Clk, Rst, EN, WR, RD, ACK, NAK;
  logic [15:0] dataIn;
  logic [3:0]  ACK_NUM;
  logic [15:0] dataOut;
  logic        EMPTY, FULL, REPLAYING, OVF, UNF, ACK_ERR;
  logic [3:0]  OCC, INFLIGHT;

  typedef struct packed {
    logic [15:0] d;
    logic        unf;
  } rsp_t;

  rsp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  replay_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .Clk(Clk), .Rst(Rst), .EN(EN), .dataIn(dataIn), .WR(WR), .RD(RD),
    .ACK(ACK), .ACK_NUM(ACK_NUM), .NAK(NAK), .dataOut(dataOut),
    .EMPTY(EMPTY), .FULL(FULL), .OCC(OCC), .INFLIGHT(INFLIGHT),
    .REPLAYING(REPLAYING), .OVF(OVF), .UNF(UNF), .ACK_ERR(ACK_ERR)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Compare a DUT value against a bench-computed expectation.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests; returns at the following falling edge.
  task automatic cyc(input logic wr, input logic [15:0] din, input logic rd,
                     input logic ack, input logic [3:0] num, input logic nak);
    WR = wr; dataIn = din; RD = rd; ACK = ack; ACK_NUM = num; NAK = nak;
    @(negedge Clk);
    WR = 1'b0; RD = 1'b0; ACK = 1'b0; ACK_NUM = 4'd0; NAK = 1'b0; dataIn = 16'h0;
  endtask

  task automatic wr1(input logic [15:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic rd1(input logic [15:0] d, input logic unf);
    rsp_t r;
    r.d = d; r.unf = unf;
    exp_q.push_back(r);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic ack1(input logic [3:0] n);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, n, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic chk_counts(input string tag, input logic empty, input logic full,
                            input logic [3:0] occ, input logic [3:0] infl, input logic rep);
    chk({tag, ".EMPTY"}, EMPTY, empty);
    chk({tag, ".FULL"}, FULL, full);
    chk({tag, ".OCC"}, OCC, occ);
    chk({tag, ".INFLIGHT"}, INFLIGHT, infl);
    chk({tag, ".REPLAYING"}, REPLAYING, rep);
  endtask

  task automatic chk_reset(input string tag);
    chk_counts(tag, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    chk({tag, ".dataOut"}, dataOut, 16'h0);
    chk({tag, ".OVF"}, OVF, 1'b0);
    chk({tag, ".UNF"}, UNF, 1'b0);
    chk({tag, ".ACK_ERR"}, ACK_ERR, 1'b0);
  endtask

  // Monitor: every read request the DUT sees produces one response to score.
  initial begin : monitor
    logic fire;
    rsp_t r;
    forever begin
      @(posedge Clk);
      fire = RD & EN & ~NAK & ~Rst;
      #1;
      if (fire) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected actual=%0h expected=none", dataOut);
        end else begin
          r = exp_q.pop_front();
          chk("rd_data", dataOut, r.d);
          chk("rd_unf", UNF, r.unf);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; EN = 1'b1; WR = 1'b0; RD = 1'b0; ACK = 1'b0; NAK = 1'b0;
    ACK_NUM = 4'd0; dataIn = 16'h0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    chk_reset("reset");

    // Basic ordering
    for (int i = 0; i < 5; i++) wr1(16'(i));
    for (int i = 0; i < 5; i++) rd1(16'(i), 1'b0);
    chk_counts("basic", 1'b1, 1'b0, 4'd5, 4'd5, 1'b0);
    ack1(4'd5);
    chk_counts("basic_ack", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);

    // Full and overflow
    for (int i = 0; i < 8; i++) wr1(16'h100 + 16'(i));
    chk_counts("full8", 1'b0, 1'b1, 4'd8, 4'd0, 1'b0);
    wr1(16'h1FF);
    chk("ovf_pulse", OVF, 1'b1);
    chk("ovf_occ", OCC, 4'd8);
    idle();
    chk("ovf_clear", OVF, 1'b0);
    for (int i = 0; i < 8; i++) rd1(16'h100 + 16'(i), 1'b0);
    chk_counts("full_read", 1'b1, 1'b1, 4'd8, 4'd8, 1'b0);
    ack1(4'd8);
    chk_counts("full_ack", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);

    // Replay
    for (int i = 0; i < 6; i++) wr1(16'hA0 + 16'(i));
    for (int i = 0; i < 4; i++) rd1(16'hA0 + 16'(i), 1'b0);
    ack1(4'd2);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b1);
    chk_counts("nak", 1'b0, 1'b0, 4'd4, 4'd0, 1'b1);
    rd1(16'hA2, 1'b0);
    chk("replay_mid", REPLAYING, 1'b1);
    rd1(16'hA3, 1'b0);
    chk("replay_done", REPLAYING, 1'b0);
    rd1(16'hA4, 1'b0);
    rd1(16'hA5, 1'b0);
    chk_counts("replay_end", 1'b1, 1'b0, 4'd4, 4'd4, 1'b0);
    ack1(4'd4);

    // Same-cycle ACK and NAK
    for (int i = 0; i < 3; i++) wr1(16'h10 + 16'(i));
    for (int i = 0; i < 3; i++) rd1(16'h10 + 16'(i), 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 4'd1, 1'b1);
    chk_counts("acknak", 1'b0, 1'b0, 4'd2, 4'd0, 1'b1);
    rd1(16'h11, 1'b0);
    rd1(16'h12, 1'b0);
    chk_counts("acknak_end", 1'b1, 1'b0, 4'd2, 4'd2, 1'b0);
    ack1(4'd2);

    // Errors
    wr1(16'h55);
    wr1(16'h66);
    rd1(16'h55, 1'b0);
    rd1(16'h66, 1'b0);
    ack1(4'd3);
    chk("ack_err_pulse", ACK_ERR, 1'b1);
    chk("ack_err_infl", INFLIGHT, 4'd2);
    ack1(4'd0);
    chk("ack_zero_ok", ACK_ERR, 1'b0);
    chk("ack_zero_infl", INFLIGHT, 4'd2);
    rd1(16'h66, 1'b1);
    idle();
    chk("unf_clear", UNF, 1'b0);
    ack1(4'd2);

    // Disabled
    EN = 1'b0;
    wr1(16'hEE);
    EN = 1'b1;
    chk_counts("disabled", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);

    // Wrap: concurrent write/read/ACK every cycle
    wr1(16'h200);
    for (int i = 0; i < 20; i++) begin
      rsp_t r;
      r.d = 16'h200 + 16'(i); r.unf = 1'b0;
      exp_q.push_back(r);
      cyc(1'b1, 16'h201 + 16'(i), 1'b1, (i > 0), (i > 0) ? 4'd1 : 4'd0, 1'b0);
      chk("wrap_occ", OCC, 4'd2);
      chk("wrap_infl", INFLIGHT, 4'd1);
    end
    rd1(16'h214, 1'b0);
    ack1(4'd2);
    chk_counts("wrap_end", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);

    // Reset during replay
    for (int i = 0; i < 3; i++) wr1(16'h31 + 16'(i));
    for (int i = 0; i < 3; i++) rd1(16'h31 + 16'(i), 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b1);
    chk("pre_rst_replay", REPLAYING, 1'b1);
    Rst = 1'b1;
    cyc(1'b1, 16'h99, 1'b1, 1'b1, 4'd1, 1'b0);
    Rst = 1'b0;
    chk_reset("mid_reset");
    wr1(16'h77);
    rd1(16'h77, 1'b0);
    chk_counts("post_reset", 1'b1, 1'b0, 4'd1, 4'd1, 1'b0);

    idle();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/replay_fifo.md
# replay_fifo

Parametrised successor to the team's 16-bit single-clock FIFO. It adds acknowledge-based retention and NAK-driven replay, so it can serve as the link-layer replay buffer. Written entries stay stored after they are read until an ACK releases them. A NAK rewinds the read pointer to the oldest unacknowledged entry, so everything in flight is re-sent in order. The block sits between the transmit framer (writer/reader) and the link-protocol controller (ACK/NAK source).

## Interface
- DATA_WIDTH, 16, entry width in bits
- ADDR_WIDTH, 3, log2 of storage depth; DEPTH = 2^ADDR_WIDTH (8)
- Clk  input  1  clock; all state updates on the rising edge
- Rst  input  1  reset, synchronous, active-high
- EN  input  1  global enable; when 0, all requests are ignored and state holds
- dataIn  input  DATA_WIDTH  write data
- WR  input  1  write request
- RD  input  1  read request
- ACK  input  1  release request
- ACK_NUM  input  ADDR_WIDTH+1  number of oldest in-flight entries to release
- NAK  input  1  replay request
- dataOut  output  DATA_WIDTH  registered read data
- EMPTY  output  1  no unread entries (RDCNT == 0)
- FULL  output  1  storage full (OCC == DEPTH)
- OCC  output  ADDR_WIDTH+1  stored entries not yet acknowledged
- INFLIGHT  output  ADDR_WIDTH+1  entries read but not yet acknowledged
- REPLAYING  output  1  read pointer is behind the pre-NAK read position
- OVF  output  1  one-cycle pulse: write rejected
- UNF  output  1  one-cycle pulse: read rejected
- ACK_ERR  output  1  one-cycle pulse: ACK rejected

## Operation
- State:
  - Pointers wr_ptr, rd_ptr and ack_ptr, each ADDR_WIDTH+1 bits, wrapping modulo 2·DEPTH.
  - replay_mark, ADDR_WIDTH+1 bits.
  - RAM of DEPTH × DATA_WIDTH, indexed by the low ADDR_WIDTH pointer bits.
- Derived values (modulo subtraction):
  - OCC = wr_ptr − ack_ptr
  - INFLIGHT = rd_ptr − ack_ptr
  - RDCNT = wr_ptr − rd_ptr
- All accept/reject decisions use pre-edge state only. Space freed by an ACK in a cycle is never usable by a WR in that same cycle.
- Write: accepted when EN & WR & !FULL.
  - Stores dataIn at wr_ptr; wr_ptr increments.
  - If WR & FULL: no store, OVF = 1 for one cycle.
- Read: accepted when EN & RD & !EMPTY & !NAK.
  - dataOut loads mem[rd_ptr]; rd_ptr increments.
  - If RD & EMPTY & !NAK: UNF = 1; dataOut holds.
  - If RD with NAK: the read is suppressed without error.
- ACK: accepted when EN & ACK & ACK_NUM ≤ INFLIGHT; ack_ptr advances by ACK_NUM.
  - ACK_NUM = 0 is accepted as a no-op.
  - If ACK_NUM > INFLIGHT: ack_ptr unchanged, ACK_ERR = 1.
- NAK (EN & NAK): evaluated after any same-cycle accepted ACK.
  - rd_ptr is set to the new ack_ptr.
  - If the new INFLIGHT > 0: replay_mark takes the pre-edge rd_ptr and REPLAYING sets.
  - Otherwise NAK is a no-op.
- REPLAYING clears on the edge where an accepted read makes rd_ptr equal replay_mark.
  - It also clears if an ACK advances ack_ptr to or past replay_mark. In that case rd_ptr is moved to ack_ptr when it lies behind it.
  - A NAK while REPLAYING restarts the replay: replay_mark is kept, not overwritten.
- WR concurrent with RD, ACK or NAK is always legal; each is applied independently.
- Wrap-around: the pointer MSB distinguishes full from empty. All counts remain correct across any number of wraps.

## Timing
- Reset (Rst = 1 at an edge, regardless of EN) sets:
  - all pointers and replay_mark to 0
  - dataOut = 0, EMPTY = 1, FULL = 0, OCC = INFLIGHT = 0
  - REPLAYING = OVF = UNF = ACK_ERR = 0
- Reset in the middle of a replay or a burst discards all contents. RAM contents are not cleared but are unreachable.
- Read latency: RD sampled at edge k gives dataOut valid after edge k; it holds until the next accepted read.
- Write-to-read: a WR accepted at edge k deasserts EMPTY after edge k, so RD may be accepted at edge k+1.
- EMPTY, FULL, OCC, INFLIGHT and REPLAYING are decoded from registers. They carry no combinational path from the inputs.
- OVF, UNF and ACK_ERR are registered and valid for exactly the cycle after the offending edge.

## Test plan
- Basic ordering: reset, then write 0x0..0x4 on consecutive cycles, then RD five cycles.
  - dataOut must be 0,1,2,3,4.
  - EMPTY = 1, INFLIGHT = 5, OCC = 5.
- Full/overflow: write 9 entries with no ACK.
  - FULL = 1 after the 8th write.
  - The 9th write raises OVF once; OCC stays 8.
  - Reading all 8 leaves FULL = 1; ACK_NUM = 8 clears it.
- Replay: write 0xA0..0xA5, read 4, ACK 2, then NAK.
  - REPLAYING = 1, INFLIGHT = 0.
  - The next reads return 0xA2, 0xA3 (REPLAYING clears here), then 0xA4, 0xA5.
- Same-cycle ACK_NUM = 1 with NAK after reading 3 of 0x10..0x12: replay starts at 0x11.
- Errors: ACK_NUM = 3 with INFLIGHT = 2 gives ACK_ERR and no pointer change; RD with EMPTY gives UNF and dataOut held.
- Wrap and reset: run 20 write/read/ACK cycles, checking data and counts across the wrap. Assert Rst mid-replay and check every output returns to its reset value.
